ft601_emulator: RTL
===================

Name: ft601_emulator

Overview:
- Synthesizable model of the FT601 chip side of the 245-synchronous FIFO bus; the counterpart to our FT601 controller.
- Drives the status flags (usb_tx_full, usb_rx_empty) and the read data/byte enables. Responds to the controller's strobes (usb_wren_l, usb_rden_l, usb_outen_l).
- A stimulus-side "host" port pushes words destined for the FPGA and pops words the FPGA wrote.
- Used for on-chip loopback and simulation of the controller/Lycan path without silicon.

Parameters:
DATA_W, 32, bus data width
BE_W, 4, byte-enable width (DATA_W/8)
RX_DEPTH, 16, host-to-FPGA buffer depth (power of 2)
TX_DEPTH, 16, FPGA-to-host buffer depth (power of 2)
CNT_W, 16, width of word/error counters

Ports:
clk  in  1  sole clock, shared with the controller
rst  in  1  synchronous, active-high reset
usb_rst_l  in  1  chip reset from controller; low = synchronous flush
usb_wren_l  in  1  controller write strobe, active low
usb_rden_l  in  1  controller read strobe, active low
usb_outen_l  in  1  controller output-enable request, active low
usb_data_i  in  DATA_W  bus value driven by controller during writes
be_i  in  BE_W  byte enables driven by controller during writes
usb_data_o  out  DATA_W  bus value driven by emulator during reads
be_o  out  BE_W  byte enables driven by emulator during reads
usb_data_oe  out  1  emulator owns the data/BE bus
usb_rx_empty  out  1  high = no word for controller to read (RXF_N)
usb_tx_full  out  1  high = cannot accept a write (TXE_N)
host_in_data  in  DATA_W  word to queue for the controller
host_in_valid  in  1  push request
host_in_ready  out  1  RX buffer not full
host_out_data  out  DATA_W  word captured from controller
host_out_be  out  BE_W  its byte enables
host_out_valid  out  1  TX buffer not empty
host_out_ready  in  1  pop acknowledge
wr_count  out  CNT_W  words accepted from controller, saturating
rd_count  out  CNT_W  words delivered to controller, saturating
overflow_err  out  1  sticky: write attempted while full
underrun_cnt  out  CNT_W  read strobes while empty, saturating
proto_err  out  1  sticky: illegal strobe combination

Behaviour:
- Reset (rst=1 or usb_rst_l=0, sampled on the clk edge):
  - Both buffers flushed. FSM to S_IDLE. Counters 0. Sticky flags cleared.
  - Outputs: usb_rx_empty=1, usb_tx_full=0, usb_data_oe=0, usb_data_o=0, be_o=0, host_out_valid=0, host_in_ready=1.
- Flags are registered and reflect buffer occupancy after the current edge's push/pop (1-cycle latency).
  - usb_rx_empty = (RX count==0).
  - usb_tx_full = (TX count==TX_DEPTH).
- FSM (states in package, enum ft601_emu_state_t):
  - S_IDLE:
    - outen_l=0 & wren_l=1 -> S_RD_ARM.
    - wren_l=0 & outen_l=1 -> S_WR.
    - Both low -> proto_err=1, stay.
    - rden_l=0 here -> proto_err=1.
  - S_RD_ARM: bus turnaround cycle. usb_data_oe=1; head word presented. No pop. rden_l=0 -> S_RD; outen_l=1 -> S_IDLE.
  - S_RD:
    - usb_data_oe=1. usb_data_o = RX head (combinational from buffer output register). be_o = all-ones if RX non-empty, else 0.
    - Each edge with rden_l=0 & outen_l=0 & RX non-empty: pop, rd_count++.
    - rden_l=0 with RX empty: no pop, underrun_cnt++, be_o=0.
    - outen_l=1 -> S_IDLE. wren_l=0 -> proto_err=1.
  - S_WR:
    - usb_data_oe=0.
    - Each edge with wren_l=0 & TX not full: push {be_i, usb_data_i}, wr_count++.
    - wren_l=0 & TX full: word dropped, overflow_err=1.
    - wren_l=1 & outen_l=0 -> S_RD_ARM; wren_l=1 & outen_l=1 -> S_IDLE.
    - rden_l=0 -> proto_err=1.
- usb_data_oe=1 only in S_RD_ARM/S_RD; outside those, usb_data_o and be_o are 0.
- Host side uses valid/ready. Push and pop on the same buffer in the same cycle are both honoured; a pop frees space for a same-cycle push only when the buffer is full.
- Pointers wrap modulo depth; count width is clog2(depth)+1.
- Counters saturate at all-ones.

Decomposition:
- Package ft601_emu_pkg: ft601_emu_state_t, FT601_DATA_W=32, FT601_BE_W=4.
- Sub-module ft601_emu_fifo: sync FIFO with count, full, empty and same-cycle push/pop. Instantiated twice: RX holds DATA_W; TX holds DATA_W+BE_W.

Test Plan:
- Host pushes 0xA0000001..0xA0000004; controller holds outen_l low for 1 cycle, then rden_l low for 4 -> usb_data_o reads the 4 words in order, be_o=0xF, rd_count=4, usb_rx_empty=1 on the edge after the 4th pop.
- Controller writes 0x12345678/be 0xF, then 0xCAFEF00D/be 0x3 -> host_out sees both in order with matching BE; wr_count=2.
- Fill TX with 16 writes, then a 17th -> usb_tx_full=1 after the 16th; 17th dropped; overflow_err=1; wr_count=16.
- rden_l held low one cycle past the last word -> underrun_cnt=1, be_o=0, no pointer change.
- wren_l and outen_l low in the same cycle -> proto_err=1 until rst.
- usb_rst_l low for 1 cycle with 5 words in RX and 3 in TX -> both empty next cycle; usb_rx_empty=1, usb_tx_full=0, FSM in S_IDLE.

Source files
------------

// File: rtl/ft601_emu_pkg.sv
// Shared types and widths for the FT601 chip-side emulator.
package ft601_emu_pkg;

   localparam int FT601_DATA_W = 32;
   localparam int FT601_BE_W   = 4;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RD_ARM = 2'd1,
      S_RD     = 2'd2,
      S_WR     = 2'd3
   } ft601_emu_state_t;

endpackage

// File: rtl/ft601_emu_fifo.sv
// Synchronous FIFO with occupancy count; a pop frees room for a same-cycle push when full.
module ft601_emu_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/ft601_emulator.sv
// Chip-side model of the FT601 245-synchronous FIFO bus, with a host-facing stimulus port.
module ft601_emulator
   import ft601_emu_pkg::*;
#(
   parameter int DATA_W   = FT601_DATA_W,
   parameter int BE_W     = FT601_BE_W,
   parameter int RX_DEPTH = 16,
   parameter int TX_DEPTH = 16,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              usb_rst_l,
   input  logic              usb_wren_l,
   input  logic              usb_rden_l,
   input  logic              usb_outen_l,
   input  logic [DATA_W-1:0] usb_data_i,
   input  logic [BE_W-1:0]   be_i,
   output logic [DATA_W-1:0] usb_data_o,
   output logic [BE_W-1:0]   be_o,
   output logic              usb_data_oe,
   output logic              usb_rx_empty,
   output logic              usb_tx_full,
   input  logic [DATA_W-1:0] host_in_data,
   input  logic              host_in_valid,
   output logic              host_in_ready,
   output logic [DATA_W-1:0] host_out_data,
   output logic [BE_W-1:0]   host_out_be,
   output logic              host_out_valid,
   input  logic              host_out_ready,
   output logic [CNT_W-1:0]  wr_count,
   output logic [CNT_W-1:0]  rd_count,
   output logic              overflow_err,
   output logic [CNT_W-1:0]  underrun_cnt,
   output logic              proto_err
);

   localparam int RXC_W = $clog2(RX_DEPTH) + 1;
   localparam int TXC_W = $clog2(TX_DEPTH) + 1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   ft601_emu_state_t        state;
   ft601_emu_state_t        state_nxt;
   logic                    flush;
   logic                    rx_pop, rx_push, rx_full, rx_empty;
   logic [RXC_W-1:0]        rx_count;
   logic [DATA_W-1:0]       rx_rdata;
   logic                    tx_push, tx_full, tx_empty, tx_accept;
   logic [TXC_W-1:0]        tx_count;
   logic [BE_W+DATA_W-1:0]  tx_rdata;
   logic                    rd_req, underrun_hit, overflow_hit, proto_hit;

   assign flush   = rst | ~usb_rst_l;
   assign rd_req  = (state == S_RD) & ~usb_rden_l & ~usb_outen_l;
   assign rx_pop  = rd_req & ~rx_empty;
   assign rx_push = host_in_valid & host_in_ready;
   assign tx_push = (state == S_WR) & ~usb_wren_l;

   // A full TX buffer still takes the write if the host drains a word on the same edge.
   assign tx_accept    = tx_push & (~tx_full | host_out_ready);
   assign overflow_hit = tx_push & ~tx_accept;
   assign underrun_hit = (state == S_RD) & ~usb_rden_l & rx_empty;
   assign proto_hit    = ((state == S_IDLE) & ((~usb_wren_l & ~usb_outen_l) | ~usb_rden_l))
                       | ((state == S_RD) & ~usb_wren_l)
                       | ((state == S_WR) & ~usb_rden_l);

   ft601_emu_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx (
      .clk(clk), .rst(flush), .push(rx_push), .wdata(host_in_data), .pop(rx_pop),
      .rdata(rx_rdata), .count(rx_count), .full(rx_full), .empty(rx_empty)
   );

   ft601_emu_fifo #(.WIDTH(BE_W + DATA_W), .DEPTH(TX_DEPTH)) u_tx (
      .clk(clk), .rst(flush), .push(tx_push), .wdata({be_i, usb_data_i}), .pop(host_out_ready),
      .rdata(tx_rdata), .count(tx_count), .full(tx_full), .empty(tx_empty)
   );

   assign host_in_ready  = ~rx_full;
   assign host_out_valid = ~tx_empty;
   assign host_out_data  = tx_rdata[DATA_W-1:0];
   assign host_out_be    = tx_rdata[BE_W+DATA_W-1:DATA_W];
   assign usb_rx_empty   = (rx_count == '0);
   assign usb_tx_full    = (tx_count == TXC_W'(TX_DEPTH));
   assign usb_data_oe    = (state == S_RD_ARM) | (state == S_RD);
   assign usb_data_o     = usb_data_oe ? rx_rdata : '0;
   assign be_o           = (usb_data_oe & ~rx_empty) ? '1 : '0;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (~usb_outen_l & usb_wren_l)      state_nxt = S_RD_ARM;
            else if (~usb_wren_l & usb_outen_l) state_nxt = S_WR;
         end
         S_RD_ARM: begin
            if (usb_outen_l)      state_nxt = S_IDLE;
            else if (~usb_rden_l) state_nxt = S_RD;
         end
         S_RD: begin
            if (usb_outen_l) state_nxt = S_IDLE;
         end
         S_WR: begin
            if (usb_wren_l) state_nxt = usb_outen_l ? S_IDLE : S_RD_ARM;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         state        <= S_IDLE;
         wr_count     <= '0;
         rd_count     <= '0;
         underrun_cnt <= '0;
         overflow_err <= 1'b0;
         proto_err    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (tx_accept)    wr_count     <= sat_inc(wr_count);
         if (rx_pop)       rd_count     <= sat_inc(rd_count);
         if (underrun_hit) underrun_cnt <= sat_inc(underrun_cnt);
         if (overflow_hit) overflow_err <= 1'b1;
         if (proto_hit)    proto_err    <= 1'b1;
      end
   end

endmodule
